// File: rtl/onehot_monitor_pkg.sv
// Shared types and helpers for the one-hot monitor.
// Index reporting is enabled by defining ONEHOT_MONITOR_INDEX_EN.
package onehot_monitor_pkg;

  typedef enum logic {
    MODE_STRICT  = 1'b0,
    MODE_ZERO_OK = 1'b1
  } onehot_mode_e;

  localparam int unsigned SAT_CALC_W = 32;

  // Saturating increment for counters up to SAT_CALC_W bits wide.
  function automatic logic [SAT_CALC_W-1:0] sat_inc(
    input logic [SAT_CALC_W-1:0] value,
    input int unsigned           width
  );
    logic [SAT_CALC_W-1:0] max_v;
    max_v = (width >= SAT_CALC_W) ? '1 : ((SAT_CALC_W'(1) << width) - SAT_CALC_W'(1));
    sat_inc = (value >= max_v) ? max_v : (value + SAT_CALC_W'(1));
  endfunction

endpackage

// File: rtl/onehot_lane_check.sv
// Combinational legality check for one lane; with ONEHOT_MONITOR_INDEX_EN
// it also encodes the position of the single set bit.
module onehot_lane_check
  import onehot_monitor_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]         lane_din,
  input  onehot_mode_e                  mode,
`ifdef ONEHOT_MONITOR_INDEX_EN
  output logic [$clog2(DATA_WIDTH)-1:0] hot_idx,
`endif
  output logic                          legal
);

  logic pow2;
  logic is_zero;

  always_comb begin
    pow2    = (lane_din & (lane_din - DATA_WIDTH'(1))) == '0;
    is_zero = (lane_din == '0);
    legal   = (mode == MODE_ZERO_OK) ? pow2 : (pow2 && !is_zero);
  end

`ifdef ONEHOT_MONITOR_INDEX_EN
  localparam int IDX_W = $clog2(DATA_WIDTH);

  // Only a legal, non-zero lane has a meaningful index.
  always_comb begin
    hot_idx = '0;
    if (legal && !is_zero) begin
      for (int b = 0; b < DATA_WIDTH; b++) begin
        if (lane_din[b]) hot_idx = IDX_W'(b);
      end
    end
  end
`endif

endmodule

// File: rtl/onehot_monitor.sv
// Registered multi-lane one-hot monitor with saturating per-lane violation
// counters, sticky error and first-error capture (ONEHOT_MONITOR_INDEX_EN adds hot_idx).
module onehot_monitor
  import onehot_monitor_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int CNT_WIDTH  = 8,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           mode,
  input  logic                           din_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   din,
  input  logic                           clr,
  output logic                           dout_valid,
  output logic [NUM_CH-1:0]              onehot,
  output logic                           sticky_err,
  output logic [NUM_CH*CNT_WIDTH-1:0]    err_cnt,
  output logic [CH_W-1:0]                first_err_ch,
`ifdef ONEHOT_MONITOR_INDEX_EN
  output logic [NUM_CH*$clog2(DATA_WIDTH)-1:0] hot_idx,
`endif
  output logic                           first_err_vld
);

  logic [NUM_CH-1:0] lane_legal;
  logic [NUM_CH-1:0] viol;

  logic                             dout_valid_q, dout_valid_d;
  logic [NUM_CH-1:0]                onehot_q, onehot_d;
  logic                             sticky_err_q, sticky_err_d;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [CH_W-1:0]                  first_err_ch_q, first_err_ch_d;
  logic                             first_err_vld_q, first_err_vld_d;

`ifdef ONEHOT_MONITOR_INDEX_EN
  localparam int IDX_W = $clog2(DATA_WIDTH);
  logic [NUM_CH-1:0][IDX_W-1:0] lane_idx;
  logic [NUM_CH-1:0][IDX_W-1:0] hot_idx_q, hot_idx_d;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    onehot_lane_check #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_check (
      .lane_din (din[i*DATA_WIDTH +: DATA_WIDTH]),
      .mode     (onehot_mode_e'(mode)),
`ifdef ONEHOT_MONITOR_INDEX_EN
      .hot_idx  (lane_idx[i]),
`endif
      .legal    (lane_legal[i])
    );
  end

  always_comb begin
    viol            = din_valid ? ~lane_legal : '0;
    dout_valid_d    = din_valid;
    onehot_d        = din_valid ? lane_legal : onehot_q;
    sticky_err_d    = sticky_err_q;
    err_cnt_d       = err_cnt_q;
    first_err_ch_d  = first_err_ch_q;
    first_err_vld_d = first_err_vld_q;

    // clr discards any violation seen in the same cycle.
    if (clr) begin
      sticky_err_d    = 1'b0;
      err_cnt_d       = '0;
      first_err_ch_d  = '0;
      first_err_vld_d = 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (viol[i]) err_cnt_d[i] = CNT_WIDTH'(sat_inc(SAT_CALC_W'(err_cnt_q[i]), CNT_WIDTH));
      end
      if (|viol) sticky_err_d = 1'b1;
      if (!first_err_vld_q && (|viol)) begin
        first_err_vld_d = 1'b1;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
          if (viol[i]) first_err_ch_d = CH_W'(i);
        end
      end
    end
  end

`ifdef ONEHOT_MONITOR_INDEX_EN
  always_comb begin
    hot_idx_d = din_valid ? lane_idx : hot_idx_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) hot_idx_q <= '0;
    else         hot_idx_q <= hot_idx_d;
  end

  assign hot_idx = hot_idx_q;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      dout_valid_q    <= 1'b0;
      onehot_q        <= '0;
      sticky_err_q    <= 1'b0;
      err_cnt_q       <= '0;
      first_err_ch_q  <= '0;
      first_err_vld_q <= 1'b0;
    end else begin
      dout_valid_q    <= dout_valid_d;
      onehot_q        <= onehot_d;
      sticky_err_q    <= sticky_err_d;
      err_cnt_q       <= err_cnt_d;
      first_err_ch_q  <= first_err_ch_d;
      first_err_vld_q <= first_err_vld_d;
    end
  end

  assign dout_valid    = dout_valid_q;
  assign onehot        = onehot_q;
  assign sticky_err    = sticky_err_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_ch  = first_err_ch_q;
  assign first_err_vld = first_err_vld_q;

endmodule

// File: tb/tb_onehot_monitor.sv
// Scoreboard bench for onehot_monitor: a reference model pushes expected state
// when stimulus is driven, and results are popped and compared one edge later.
module tb_onehot_monitor;

  localparam int DW    = 32;
  localparam int NCH   = 4;
  localparam int CW    = 2;
  localparam int CHW   = 2;
  localparam int IDXW  = 5;

  logic                 clk;
  logic                 resetn;
  logic                 mode;
  logic                 din_valid;
  logic [NCH*DW-1:0]    din;
  logic                 clr;
  logic                 dout_valid;
  logic [NCH-1:0]       onehot;
  logic                 sticky_err;
  logic [NCH*CW-1:0]    err_cnt;
  logic [CHW-1:0]       first_err_ch;
  logic                 first_err_vld;
`ifdef ONEHOT_MONITOR_INDEX_EN
  logic [NCH*IDXW-1:0]  hot_idx;
`endif

  onehot_monitor #(
    .DATA_WIDTH (DW),
    .NUM_CH     (NCH),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .mode          (mode),
    .din_valid     (din_valid),
    .din           (din),
    .clr           (clr),
    .dout_valid    (dout_valid),
    .onehot        (onehot),
    .sticky_err    (sticky_err),
    .err_cnt       (err_cnt),
    .first_err_ch  (first_err_ch),
`ifdef ONEHOT_MONITOR_INDEX_EN
    .hot_idx       (hot_idx),
`endif
    .first_err_vld (first_err_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic                dv;
    logic [NCH-1:0]      oh;
    logic                sticky;
    logic [NCH*CW-1:0]   cnt;
    logic [CHW-1:0]      fch;
    logic                fvld;
    logic [NCH*IDXW-1:0] idx;
  } exp_t;

  exp_t exp_q[$];
  exp_t model;

  int compared   = 0;
  int mismatched = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Reference model, written from the behavioural description of the monitor.
  task automatic modelStep(input logic rst_n, input logic md, input logic vld,
                           input logic [NCH*DW-1:0] d, input logic c);
    logic [DW-1:0]  x;
    logic [NCH-1:0] legal;
    logic [NCH-1:0] v;
    int             cnt;
    if (!rst_n) begin
      model = '0;
      return;
    end
    for (int i = 0; i < NCH; i++) begin
      x        = d[i*DW +: DW];
      legal[i] = md ? ($countones(x) <= 1) : ($countones(x) == 1);
      v[i]     = vld && !legal[i];
      if (vld) model.idx[i*IDXW +: IDXW] = (legal[i] && x != 0) ? IDXW'($clog2(x)) : '0;
    end
    model.dv = vld;
    if (vld) model.oh = legal;
    if (c) begin
      model.sticky = 1'b0;
      model.cnt    = '0;
      model.fch    = '0;
      model.fvld   = 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt = int'(model.cnt[i*CW +: CW]);
        if (v[i] && cnt < 3) model.cnt[i*CW +: CW] = CW'(cnt + 1);
      end
      if (v != 0) model.sticky = 1'b1;
      if (!model.fvld && v != 0) begin
        model.fvld = 1'b1;
        for (int i = 0; i < NCH; i++) begin
          if (v[i]) begin
            model.fch = CHW'(i);
            break;
          end
        end
      end
    end
  endtask

  task automatic applyStimulus(input string tag, input logic rst_n, input logic md, input logic vld,
                               input logic [NCH*DW-1:0] d, input logic c);
    exp_t e;
    resetn    = rst_n;
    mode      = md;
    din_valid = vld;
    din       = d;
    clr       = c;
    modelStep(rst_n, md, vld, d, c);
    exp_q.push_back(model);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checkOutput({tag, ".dout_valid"},    32'(dout_valid),    32'(e.dv));
    checkOutput({tag, ".onehot"},        32'(onehot),        32'(e.oh));
    checkOutput({tag, ".sticky_err"},    32'(sticky_err),    32'(e.sticky));
    checkOutput({tag, ".err_cnt"},       32'(err_cnt),       32'(e.cnt));
    checkOutput({tag, ".first_err_ch"},  32'(first_err_ch),  32'(e.fch));
    checkOutput({tag, ".first_err_vld"}, 32'(first_err_vld), 32'(e.fvld));
`ifdef ONEHOT_MONITOR_INDEX_EN
    checkOutput({tag, ".hot_idx"},       32'(hot_idx),       32'(e.idx));
`endif
  endtask

  function automatic logic [DW-1:0] pickLane();
    case ($urandom_range(0, 3))
      0:       pickLane = '0;
      1, 2:    pickLane = DW'(1) << $urandom_range(0, DW - 1);
      default: pickLane = DW'($urandom);
    endcase
  endfunction

  localparam logic [NCH*DW-1:0] LANES_MIX = {32'h6, 32'h0, 32'h8000_0000, 32'h1};
  localparam logic [NCH*DW-1:0] ALL_ONE   = {32'h1, 32'h1, 32'h1, 32'h1};

  initial begin
    logic [NCH*DW-1:0] rnd;
    resetn = 1'b0; mode = 1'b0; din_valid = 1'b0; din = '0; clr = 1'b0;
    #2;

    // Reset then idle
    applyStimulus("rst0", 1'b0, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus("rst1", 1'b0, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus("idle", 1'b1, 1'b0, 1'b0, '0, 1'b0);

    // Strict mode mixed lanes, then a hold cycle
    applyStimulus("strict", 1'b1, 1'b0, 1'b1, LANES_MIX, 1'b0);
    checkOutput("strict.onehot_lit", 32'(onehot), 32'h3);
    checkOutput("strict.fch_lit", 32'(first_err_ch), 32'd2);
    applyStimulus("hold", 1'b1, 1'b0, 1'b0, '1, 1'b0);

    // Zero-ok mode after clearing
    applyStimulus("clr0", 1'b1, 1'b0, 1'b0, '0, 1'b1);
    applyStimulus("zerook", 1'b1, 1'b1, 1'b1, LANES_MIX, 1'b0);
    checkOutput("zerook.onehot_lit", 32'(onehot), 32'h7);
    checkOutput("zerook.fch_lit", 32'(first_err_ch), 32'd3);

    // Saturation on lane 0
    applyStimulus("clr1", 1'b1, 1'b0, 1'b0, '0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus($sformatf("sat%0d", k), 1'b1, 1'b0, 1'b1, {ALL_ONE[NCH*DW-1:DW], 32'h3}, 1'b0);
    end
    checkOutput("sat.lane0_lit", 32'(err_cnt[CW-1:0]), 32'd3);

    // clr racing a violation
    applyStimulus("clr2", 1'b1, 1'b0, 1'b0, '0, 1'b1);
    applyStimulus("clrA", 1'b1, 1'b0, 1'b1, {32'h1, 32'h1, 32'h3, 32'h1}, 1'b0);
    applyStimulus("clrB", 1'b1, 1'b0, 1'b1, {32'h1, 32'h1, 32'h1, 32'h0}, 1'b1);
    applyStimulus("clrC", 1'b1, 1'b0, 1'b1, {32'h1, 32'h5, 32'h1, 32'h1}, 1'b0);
    checkOutput("clrC.fch_lit", 32'(first_err_ch), 32'd2);

    // Reset mid-stream with a concurrent violation
    applyStimulus("acc0", 1'b1, 1'b0, 1'b1, {32'h0, 32'h3, 32'h1, 32'h0}, 1'b0);
    applyStimulus("midrst", 1'b0, 1'b0, 1'b1, {32'h0, 32'h0, 32'h0, 32'h0}, 1'b1);
    applyStimulus("postrst", 1'b1, 1'b0, 1'b0, '0, 1'b0);

    // Random traffic over both modes
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < NCH; i++) rnd[i*DW +: DW] = pickLane();
      applyStimulus($sformatf("rnd%0d", k), 1'b1, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) != 0), rnd, 1'($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/onehot_monitor.md
Name: onehot_monitor

Overview:
Multi-channel, registered one-hot checker for protocol/FSM state buses.
- Every valid cycle, each of NUM_CH lanes of DATA_WIDTH bits is checked against the selected encoding mode.
- Per-lane results are registered and reported together.
- Per-lane violations are counted in saturating counters, with a sticky error flag and capture of the first failing lane.
- Sits beside datapath/control blocks as a lightweight assertion-in-silicon monitor readable by status logic.

Parameters:
- DATA_WIDTH, 32, bits per lane; legal range ≥2.
- NUM_CH, 4, number of monitored lanes; legal range ≥2.
- CNT_WIDTH, 8, width of each per-lane violation counter.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- resetn  input  1  synchronous active-low reset.
- mode  input  1  0 = strict one-hot (exactly one bit set); 1 = one-hot-or-zero (at most one bit set).
- din_valid  input  1  qualifies din this cycle.
- din  input  NUM_CH*DATA_WIDTH  lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- clr  input  1  clears counters, sticky flag and first-error capture.
- dout_valid  output  1  onehot is valid this cycle.
- onehot  output  NUM_CH  per-lane pass flag, 1 = lane legal under mode.
- sticky_err  output  1  set by any violation since reset/clr.
- err_cnt  output  NUM_CH*CNT_WIDTH  per-lane saturating violation count.
- first_err_ch  output  max(1,$clog2(NUM_CH))  lane index of first violation since reset/clr.
- first_err_vld  output  1  first_err_ch holds a captured value.

Behaviour:
- Reset (resetn=0 at a clk edge):
  - dout_valid=0, onehot=0, sticky_err=0, err_cnt=0, first_err_ch=0, first_err_vld=0.
  - Reset overrides clr and din_valid in the same cycle.
- Check per lane x (combinational):
  - pow2 = (x & (x-1)) == 0.
  - strict: legal = pow2 && x != 0.
  - zero-ok: legal = pow2.
  - mode is sampled in the same cycle as din.
- Latency 1:
  - din_valid at edge t gives dout_valid=1 and onehot=per-lane legal after edge t.
  - din_valid=0 gives dout_valid=0; onehot holds its previous value.
- Violation: din_valid=1 and lane legal=0.
  - err_cnt[i] increments by 1 per violating cycle.
  - err_cnt[i] saturates at 2^CNT_WIDTH-1 and never wraps.
  - Multiple lanes may increment in the same cycle.
- sticky_err: set on any violation; held until clr or reset.
- First-error capture:
  - Occurs only when first_err_vld=0 and a violation occurs.
  - first_err_ch = lowest-index violating lane; first_err_vld=1.
  - Later violations do not update the capture.
- clr=1:
  - Next cycle: err_cnt=0, sticky_err=0, first_err_vld=0, first_err_ch=0.
  - A violation in the same cycle as clr is discarded for counters and capture; clr wins.
  - onehot/dout_valid still report that cycle's check normally.
- Counters, sticky flag and capture update on the same edge as onehot; all outputs are mutually consistent in any cycle.
- No X propagation: all state registers are reset.

Optional Feature:
- Macro ONEHOT_MONITOR_INDEX_EN.
- When defined:
  - Adds output hot_idx, width NUM_CH*$clog2(DATA_WIDTH).
  - Holds the binary index of the set bit per lane, registered with the same latency/enable as onehot.
  - Value is 0 when the lane is zero or illegal.
  - Reset value 0.
- When undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package onehot_monitor_pkg holds:
  - typedef enum logic {MODE_STRICT=1'b0, MODE_ZERO_OK=1'b1} onehot_mode_e.
  - A localparam function for saturating increment.
- One sub-module: onehot_lane_check. Combinational per-lane legal check, plus index encode under the macro; instantiated NUM_CH times via generate.
- Counters, capture and output registers live in onehot_monitor.

Test Plan:
1. Reset then idle: resetn low 2 cycles, din_valid=0 → all outputs 0, dout_valid stays 0.
2. Strict mode, DATA_WIDTH=32, NUM_CH=4, lanes {0x1, 0x80000000, 0x0, 0x6} with din_valid=1 → next cycle onehot=4'b0011, err_cnt lane2=1, lane3=1, sticky_err=1, first_err_ch=2. With INDEX_EN: hot_idx lane0=0, lane1=31.
3. Zero-ok mode, same lanes → onehot=4'b0111; only lane3 counts; first_err_ch=3.
4. Saturation: CNT_WIDTH=2, lane0=0x3 for 5 valid cycles → err_cnt lane0 = 1,2,3,3,3.
5. clr with simultaneous violation:
   - Cycle A: lane1 violates, capture = 1.
   - Cycle B: clr=1 and lane0 violates → after B, counters=0, sticky_err=0, first_err_vld=0, onehot lane0=0.
   - Cycle C: lane2 violates → first_err_ch=2, err_cnt lane2=1.
6. Reset mid-stream: violations accumulating, resetn=0 concurrently with din_valid=1 and a violation → all state returns to 0 next cycle; no increment recorded.
